// File: rtl/mc_riscv_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb with ready handshakes,
// memory watchdog and sticky error flags. Optional branches via `MC_BRANCH_EN.
module mc_riscv_controller #(
  parameter int ALU_CC_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_read,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                illegal_instr,
  output logic                bus_err,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired_count
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);
  localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(4'b1100);

  state_t              r_state, w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_illegal, r_bus_err;
  logic [CNT_W-1:0]    r_retired;
  logic                w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_taken;
  logic                w_legal, w_timeout, w_retire, w_set_ill, w_set_bus;
  logic [ALU_CC_W-1:0] w_cc;

  assign w_is_r    = (opcode == OP_R);
  assign w_is_i    = (opcode == OP_I);
  assign w_is_lw   = (opcode == OP_LW);
  assign w_is_sw   = (opcode == OP_SW);
  assign w_timeout = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

`ifdef MC_BRANCH_EN
  assign w_is_br = (opcode == 7'b1100011);
  assign w_taken = (funct3 == 3'b000) ? zero : ~zero;
  assign w_legal = w_is_r || w_is_i || ((w_is_lw || w_is_sw) && funct3 == 3'b010)
                 || (w_is_br && (funct3 == 3'b000 || funct3 == 3'b001));
`else
  logic w_unused_zero;
  assign w_unused_zero = zero;
  assign w_is_br = 1'b0;
  assign w_taken = 1'b0;
  assign w_legal = w_is_r || w_is_i || ((w_is_lw || w_is_sw) && funct3 == 3'b010);
`endif

  // Operation select; SUB only for R-type, immediate forms ignore funct7.
  always_comb begin
    w_cc = CC_ADD;
    if (w_is_br) begin
      w_cc = CC_SUB;
    end else if (w_is_r || w_is_i) begin
      case (funct3)
        3'b000:  w_cc = (w_is_r && funct7 == 7'b0100000) ? CC_SUB : CC_ADD;
        3'b100:  w_cc = CC_XOR;
        3'b110:  w_cc = CC_OR;
        3'b111:  w_cc = CC_AND;
        3'b010:  w_cc = CC_SLT;
        default: w_cc = CC_ADD;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_set_ill = 1'b0;
    w_set_bus = 1'b0;
    imem_read = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_cc    = '0;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: begin
        imem_read = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus = 1'b1;
          w_next    = S_TRAP;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_set_ill = 1'b1;
          w_next    = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src = w_is_i || w_is_lw || w_is_sw;
        alu_cc  = w_cc;
        if (w_is_br) begin
          pc_write = w_taken;
          pc_src   = w_taken;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        alu_cc    = w_cc;
        mem_read  = w_is_lw;
        mem_write = w_is_sw;
        // A ready arriving on the limit cycle takes priority over the trap.
        if (dmem_ready) begin
          w_retire = w_is_sw;
          w_next   = w_is_lw ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_set_bus = 1'b1;
          w_next    = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = w_is_lw;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_RST;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + WAIT_W'(1);
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus_err <= 1'b1;
      if (w_retire)  r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign illegal_instr = r_illegal;
  assign bus_err       = r_bus_err;
  assign state_o       = r_state;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_mc_riscv_controller.sv
// Randomized self-checking bench for mc_riscv_controller against an
// instruction-level expectation model; honours `MC_BRANCH_EN.
module tb_mc_riscv_controller;

  localparam int TO = 16;

  localparam int B_IMR = 256, B_IRW = 128, B_PCW = 64, B_PCS = 32, B_RW = 16;
  localparam int B_M2R = 8, B_AS = 4, B_MR = 2, B_MW = 1;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_BAD = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_read, ir_write, pc_write, pc_src, reg_write, mem2reg;
  logic        alu_src, mem_read, mem_write, illegal_instr, bus_err;
  logic [3:0]  alu_cc;
  logic [2:0]  state_o;
  logic [31:0] retired_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        exp_ill = 1'b0;
  logic        exp_bus = 1'b0;
  logic [31:0] exp_ret = '0;

  mc_riscv_controller #(.ALU_CC_W(4), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .alu_cc(alu_cc), .illegal_instr(illegal_instr),
    .bus_err(bus_err), .state_o(state_o), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b1100011: return K_BR;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic bit is_legal(input int k, input logic [2:0] f3);
    if (k == K_R || k == K_I) return 1'b1;
    if (k == K_LW || k == K_SW) return f3 == 3'd2;
`ifdef MC_BRANCH_EN
    if (k == K_BR) return f3 <= 3'd1;
`endif
    return 1'b0;
  endfunction

  function automatic int exp_cc(input int k, input logic [2:0] f3, input logic [6:0] f7);
    if (k == K_LW || k == K_SW) return 2;
    if (k == K_BR) return 6;
    case (f3)
      3'd0:    return (k == K_R && f7 == 7'b0100000) ? 6 : 2;
      3'd4:    return 12;
      3'd6:    return 1;
      3'd7:    return 0;
      3'd2:    return 7;
      default: return 2;
    endcase
  endfunction

  // One clock cycle: check outputs shortly after the falling edge, then advance.
  task automatic step(input int st, input int sb, input int cc);
    #1;
    check("state", state_o, st);
    check("strobes", {imem_read, ir_write, pc_write, pc_src, reg_write, mem2reg,
                      alu_src, mem_read, mem_write}, sb);
    check("alu_cc", alu_cc, cc);
    check("illegal_instr", illegal_instr, exp_ill);
    check("bus_err", bus_err, exp_bus);
    check("retired_count", retired_count, exp_ret);
    @(negedge clk);
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      step(6, 0, 0);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset      = 1'b0;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    @(negedge clk);
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    exp_ret = '0;
    for (int i = 0; i < cycles; i++) step(0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);
  endtask

  // Walks one instruction from FETCH; fd/md are cycles before each ready rises.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input int fd, input int md);
    int  k;
    bit  rdy;
    bit  taken;
    k = kind_of(op);
    opcode = op; funct3 = f3; funct7 = f7; zero = z;
    dmem_ready = 1'b0;
    rdy = 1'b0;
    for (int c = 0; c < TO; c++) begin
      rdy = (c >= fd);
      imem_ready = rdy;
      step(1, rdy ? (B_IMR + B_IRW + B_PCW) : B_IMR, 0);
      if (rdy) break;
    end
    imem_ready = 1'b0;
    if (!rdy) begin
      exp_bus = 1'b1;
      trap_tail();
      return;
    end
    step(2, 0, 0);
    if (!is_legal(k, f3)) begin
      exp_ill = 1'b1;
      trap_tail();
      return;
    end
    if (k == K_BR) begin
      taken = (f3 == 3'd0) ? z : !z;
      step(3, taken ? (B_PCW + B_PCS) : 0, 6);
      exp_ret++;
      return;
    end
    step(3, (k == K_R) ? 0 : B_AS, exp_cc(k, f3, f7));
    if (k == K_LW || k == K_SW) begin
      rdy = 1'b0;
      for (int c = 0; c < TO; c++) begin
        rdy = (c >= md);
        dmem_ready = rdy;
        step(4, (k == K_LW) ? B_MR : B_MW, 2);
        if (rdy) break;
      end
      dmem_ready = 1'b0;
      if (!rdy) begin
        exp_bus = 1'b1;
        trap_tail();
        return;
      end
      if (k == K_SW) begin
        exp_ret++;
        return;
      end
    end
    step(5, (k == K_LW) ? (B_RW + B_M2R) : B_RW, 0);
    exp_ret++;
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input int fd, input int md);
    do_instr(op, f3, f7, z, fd, md);
    if (exp_ill || exp_bus) do_reset(1);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sel, fd, md;

    @(negedge clk);
    do_reset(2);

    run(7'b0110011, 3'd0, 7'd0, 1'b0, 0, 0);            // ADD
    run(7'b0000011, 3'd2, 7'd0, 1'b0, 0, 3);            // LW, ready after 3
    run(7'b0100011, 3'd2, 7'd0, 1'b0, 0, 1000);         // SW, dmem never ready
    run(7'b1111111, 3'd0, 7'd0, 1'b0, 0, 0);            // illegal opcode
    run(7'b0010011, 3'd0, 7'b0100000, 1'b0, 0, 0);      // ADDI ignores funct7
    run(7'b0110011, 3'd0, 7'b0100000, 1'b0, 0, 0);      // SUB
    run(7'b0000011, 3'd3, 7'd0, 1'b0, 0, 0);            // LW with bad funct3
    run(7'b0010011, 3'd4, 7'd0, 1'b0, TO - 1, 0);       // fetch ready on limit cycle
    run(7'b0100011, 3'd2, 7'd0, 1'b0, 1, TO - 1);       // mem ready on limit cycle
    run(7'b0110011, 3'd7, 7'd0, 1'b0, TO, 0);           // fetch timeout
    run(7'b1100011, 3'd0, 7'd0, 1'b1, 0, 0);            // BEQ, zero=1
    run(7'b1100011, 3'd1, 7'd0, 1'b1, 0, 0);            // BNE, zero=1

    // Reset during a stalled load must abort with no strobes afterwards.
    opcode = 7'b0000011; funct3 = 3'd2; funct7 = '0;
    imem_ready = 1'b1;
    step(1, B_IMR + B_IRW + B_PCW, 0);
    imem_ready = 1'b0;
    step(2, 0, 0);
    step(3, B_AS, 2);
    dmem_ready = 1'b0;
    step(4, B_MR, 2);
    do_reset(1);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: op = 7'b0110011;
        2:    op = 7'b0010011;
        3:    op = 7'b0000011;
        4:    op = 7'b0100011;
        5:    op = 7'b1100011;
        6:    op = 7'b1111111;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      if ((op == 7'b0000011 || op == 7'b0100011) && $urandom_range(0, 4) != 0) f3 = 3'd2;
      if (op == 7'b1100011 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       f7 = 7'd0;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      fd = ($urandom_range(0, 11) == 0) ? TO + 2 : $urandom_range(0, 3);
      md = ($urandom_range(0, 11) == 0) ? TO + 2 : $urandom_range(0, 4);
      run(op, f3, f7, 1'($urandom), fd, md);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_riscv_controller.md
Name: mc_riscv_controller

Overview:
- Multi-cycle control unit for the RV32I `data_path` block; supersedes the single-cycle combinational control decode.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Supports stalling instruction and data memories through ready handshakes, a memory-timeout watchdog and sticky error trapping.
- Drives the existing `data_path` control pins (reg_write, mem2reg, alu_src, mem_read, mem_write, alu_cc) plus new multi-cycle strobes.

Parameters:
- ALU_CC_W, 4: width of alu_cc.
- MEM_TIMEOUT, 16: maximum cycles to wait for any ready signal before trapping; must be at least 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  synchronous, active-low reset.
- opcode  input  7  instruction bits [6:0], taken from the IR.
- funct3  input  3  instruction bits [14:12].
- funct7  input  7  instruction bits [31:25].
- zero  input  1  ALU zero flag.
- imem_ready  input  1  instruction memory has data.
- dmem_ready  input  1  data memory access complete.
- imem_read  output  1  instruction fetch request.
- ir_write  output  1  load the IR.
- pc_write  output  1  update the PC.
- pc_src  output  1  0 = PC+4, 1 = branch target.
- reg_write  output  1  register file write enable.
- mem2reg  output  1  writeback source is memory.
- alu_src  output  1  ALU operand B is the immediate.
- mem_read  output  1  data memory read.
- mem_write  output  1  data memory write.
- alu_cc  output  ALU_CC_W  ALU operation code.
- illegal_instr  output  1  sticky flag: undecodable instruction.
- bus_err  output  1  sticky flag: memory timeout.
- state_o  output  3  current state encoding, for debug.
- retired_count  output  CNT_W  number of completed instructions.

Behaviour:
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- All outputs are decoded from the registered state and the opcode/funct inputs (Moore outputs plus alu_cc decode). Nothing asserts in RST.
- Reset:
  - reset=0 at a clock edge forces RST, zeroes the wait counter, clears illegal_instr and bus_err, and zeroes retired_count.
  - Reset applied mid-instruction aborts the instruction; no write strobe is asserted in the following cycle.
- RST: always goes to FETCH on the next edge.
- FETCH:
  - imem_read=1.
  - If imem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise hold FETCH and increment the wait counter.
- DECODE:
  - One cycle, no strobes.
  - Legal opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW). Any other opcode goes to TRAP with illegal_instr=1.
  - A LW or SW with funct3 other than 010 also goes to TRAP with illegal_instr=1.
- EXEC:
  - alu_src=1 for I-ALU, LW and SW.
  - R and I-ALU go to WB; LW and SW go to MEM.
- MEM:
  - mem_read=1 for LW; mem_write=1 for SW. The strobe is held until dmem_ready=1.
  - On ready, LW goes to WB.
  - On ready, SW goes to FETCH and retired_count increments by 1.
- WB:
  - reg_write=1 for exactly one cycle; mem2reg=1 for LW.
  - Goes to FETCH; retired_count increments by 1.
- alu_cc decode (valid in EXEC and MEM):
  - funct3 000: 0010 (ADD). For R-type only, funct7=0100000 gives 0110 (SUB); for I-type, funct7 is ignored.
  - funct3 100: 1100 (XOR).
  - funct3 110: 0001 (OR).
  - funct3 111: 0000 (AND).
  - funct3 010: 0111 (SLT).
  - LW/SW: 0010.
  - Any other funct3: 0010.
  - In all other states: 0000.
- Watchdog:
  - The wait counter clears on every state change.
  - If the counter reaches MEM_TIMEOUT while waiting in FETCH or MEM, go to TRAP with bus_err=1.
  - A ready that arrives in the same cycle the counter hits the limit wins; no trap occurs.
- TRAP:
  - Absorbing state: all strobes are 0 and the error flags hold.
  - The only exit is reset.
- retired_count wraps modulo 2^CNT_W.

Optional Feature:
- Macro: MC_BRANCH_EN.
- Defined:
  - Opcode 1100011 is legal, with funct3 000 (BEQ) or 001 (BNE); any other funct3 traps.
  - EXEC: alu_cc=0110; taken = zero for BEQ, ~zero for BNE.
  - If taken: pc_write=1 and pc_src=1.
  - Next state is FETCH; retired_count increments by 1.
- Undefined: opcode 1100011 traps with illegal_instr=1, and pc_src is tied to 0.

Test Plan:
- Reset held 2 cycles, then ADD R-type (funct7=0, funct3=000), with imem_ready and dmem_ready tied to 1 -> states 1,2,3,5,1; alu_cc=0010 in EXEC; reg_write high only in WB; retired_count=1.
- LW (funct3=010) with dmem_ready delayed 3 cycles -> mem_read held for 4 cycles of MEM; mem2reg=1 and reg_write=1 in WB; retired_count increments once.
- SW with dmem_ready never asserted, MEM_TIMEOUT=16 -> after 16 cycles in MEM, state_o=6, bus_err=1 and mem_write=0; stays in TRAP until reset=0.
- Opcode 1111111 -> DECODE goes to TRAP with illegal_instr=1; reg_write, mem_write and pc_write stay 0 forever; a reset pulse clears illegal_instr and restarts at FETCH.
- ADDI with funct7=0100000 -> alu_cc=0010 (not 0110); SUB R-type -> alu_cc=0110.
- With MC_BRANCH_EN: BEQ with zero=1 -> EXEC has pc_write=1, pc_src=1, alu_cc=0110; BNE with zero=1 -> pc_write=0 in EXEC and next state FETCH.
